shift_arbiter: RTL and testbench
================================

Name: shift_arbiter

Overview:
- Shares one 16-bit right shift/rotate datapath between two requesters: port 0 is the execute-stage ALU and port 1 is the multi-cycle/aux unit.
- Arbitrates round-robin, maps all four ISA shift ops onto the single right shifter, and holds the result in a one-entry registered response buffer.
- Uses valid/ready handshakes on both sides.
- Sits beside the ALU and replaces per-unit shifter instances.

Parameters:
- INIT_PTR, 0: round-robin pointer value after reset (the requester favoured first).
- RESP_HOLD, 1: 1 holds the response until taken (rsp_ready); 0 treats the response as always taken in the cycle it is valid.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_in  in  16  requester 0 operand
- req0_op  in  2  00 ROL, 01 SLL, 10 ROR, 11 SRL
- req0_amt  in  4  shift amount, 0..15
- req1_valid, req1_ready, req1_in, req1_op, req1_amt: same as port 0, for requester 1
- rsp_valid  out  2  one-hot result-valid per requester
- rsp_ready  in  2  per-requester result accept
- rsp_data  out  16  result, shared bus, meaningful for the requester flagged in rsp_valid
- busy  out  1  response buffer occupied

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: rsp_valid=00, rsp_data=0000, busy=0, pointer=INIT_PTR. req*_ready is combinational and 0 while rst is high.
- State machine, two states:
  - EMPTY: buffer free.
  - FULL: result held for the owner.
  - EMPTY->FULL on any accept.
  - FULL->EMPTY when the owner's rsp_ready=1 and no accept occurs that cycle.
  - FULL->FULL on take-and-accept in the same cycle.
- Accept condition: can_accept = EMPTY, or (FULL and rsp_ready[owner]=1). Both requests being valid never stalls a free slot.
- Grant rules:
  - One grant at most per cycle.
  - Only one requester valid: grant it.
  - Both valid: grant the pointer's requester, then set the pointer to the other requester.
  - The pointer updates only on a contended grant.
  - reqN_ready = can_accept and grant==N.
- Latency: operation accepted at edge N; rsp_valid[owner]=1 and rsp_data valid after edge N, i.e. 1 cycle.
- Op mapping onto the right shifter (shift=1 logical, shift=0 rotate):
  - ROR: right rotate by amt.
  - SRL: right shift by amt, zero fill.
  - ROL: right rotate by (16-amt) mod 16. amt=0 gives an identity rotate.
  - SLL: bit-reverse the operand, right shift by amt, bit-reverse the result.
  - amt=0: result equals the operand for all ops.
- Width: all amounts are 4-bit mod-16 arithmetic; no amount outside 0..15 exists.
- Stability: rsp_data and rsp_valid are stable while FULL and not taken. Requesters must hold in/op/amt while valid and not ready; the block samples only on accept.
- RESP_HOLD=0: the buffer empties every cycle and rsp_ready is ignored.
- Reset mid-operation: the held result is discarded, the pointer returns to INIT_PTR, and no ready is asserted in the reset cycle.

Optional Feature:
- Macro: SHIFT_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, requester 0 always wins on contention; the pointer logic is removed.
- Undefined: round-robin as above.
- The bench must run both builds.

Test Plan:
- Reset, then req0 SRL in=8000 amt=F -> req0_ready=1, next cycle rsp_valid=01, rsp_data=0001.
- req1 ROL in=8001 amt=1, and separately amt=0 -> rsp_data=0003 and 8001 respectively, rsp_valid=10.
- req0 SLL in=0001 amt=F -> rsp_data=8000. req0 ROR in=0001 amt=4 -> rsp_data=1000.
- Contention, INIT_PTR=0:
  - Both valid 4 cycles, rsp_ready=11 -> grants 0,1,0,1; back-to-back rsp_valid with no bubble.
  - Same stimulus with SHIFT_ARB_FIXED_PRIO_EN defined -> grants 0,0,0,0.
- Backpressure: result FULL for req0 with rsp_ready=00 for 3 cycles -> both readies 0, rsp_data held. rsp_ready=01 with req1 valid -> req1 accepted the same cycle, next rsp_valid=10.
- Assert rst while FULL -> next cycle rsp_valid=00, busy=0, pointer=INIT_PTR; a pending request is accepted only after rst drops.

Source files
------------

// File: rtl/shift_arbiter.sv
// -----------------------------------------------------------------------------
// shift_arbiter
//
// Two requesters share one 16-bit right shift/rotate datapath:
//   - port 0: the execute-stage ALU
//   - port 1: the multi-cycle/aux unit
//
// Operation:
//   - Arbitration is round-robin.
//   - All four ISA shift ops are mapped onto a single right barrel shifter.
//   - The result sits in a one-entry registered response buffer until its
//     owner takes it.
//
// Configuration:
//   - SHIFT_ARB_FIXED_PRIO_EN (macro): when defined, requester 0 always wins
//     on contention and the round-robin pointer is not built.
//   - INIT_PTR: requester favoured first after reset.
//   - RESP_HOLD: 1 holds the response until rsp_ready; 0 treats the response
//     as taken in the cycle it is presented.
//
// Ports:
//   - clk, rst          : clock and synchronous active-high reset
//   - reqN_valid/ready  : request handshake; reqN_ready is combinational
//   - reqN_in/op/amt    : operand, op (00 ROL, 01 SLL, 10 ROR, 11 SRL),
//                         amount (0..15)
//   - rsp_valid [1:0]   : one-hot result valid per requester
//   - rsp_ready [1:0]   : per-requester result accept
//   - rsp_data  [15:0]  : shared result bus
//   - busy              : response buffer occupied
// -----------------------------------------------------------------------------
module shift_arbiter #(
    parameter logic INIT_PTR  = 1'b0,
    parameter bit   RESP_HOLD = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [15:0] req0_in,
    input  logic [1:0]  req0_op,
    input  logic [3:0]  req0_amt,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [15:0] req1_in,
    input  logic [1:0]  req1_op,
    input  logic [3:0]  req1_amt,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [15:0] rsp_data,
    output logic        busy
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    localparam logic [1:0] OP_ROL = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;

    state_t      r_state;
    logic        r_owner;
    logic [1:0]  r_rsp_valid;
    logic [15:0] r_rsp_data;

    logic        w_taken;
    logic        w_can_accept;
    logic        w_contend;
    logic        w_grant;
    logic        w_accept;
    logic [15:0] w_in;
    logic [1:0]  w_op;
    logic [3:0]  w_amt;
    logic [3:0]  w_rot_amt;
    logic        w_logical;
    logic [15:0] w_pre;
    logic [15:0] w_pre_rev;
    logic [15:0] w_shifted;
    logic [15:0] w_shifted_rev;
    logic [15:0] w_result;
    logic [15:0] w_stage [0:4];

    // ------------------------------------------------------------------
    // Buffer release and accept
    // ------------------------------------------------------------------
    // With RESP_HOLD=0 the held result is considered consumed every cycle,
    // so rsp_ready never gates anything.
    always_comb begin
        w_taken = 1'b0;
        if (r_state == ST_FULL) begin
            w_taken = RESP_HOLD ? rsp_ready[r_owner] : 1'b1;
        end
    end

    assign w_can_accept = !rst && ((r_state == ST_EMPTY) || w_taken);
    assign w_contend    = req0_valid && req1_valid;

`ifdef SHIFT_ARB_FIXED_PRIO_EN
    // Requester 0 wins whenever it is valid.
    assign w_grant = !req0_valid;

    // INIT_PTR has no meaning without the pointer; it is only tied off here
    // so the parameter list stays identical between builds.
    logic w_unused_init_ptr;
    assign w_unused_init_ptr = INIT_PTR;
`else
    logic r_ptr;

    // Uncontended: the lone valid requester wins. Contended: the pointer
    // decides.
    assign w_grant = w_contend ? r_ptr : req1_valid;
`endif

    assign w_accept   = w_can_accept && (req0_valid || req1_valid);
    assign req0_ready = w_accept && !w_grant;
    assign req1_ready = w_accept &&  w_grant;

    // ------------------------------------------------------------------
    // Operand select and op mapping onto a single right shifter
    // ------------------------------------------------------------------
    assign w_in  = w_grant ? req1_in  : req0_in;
    assign w_op  = w_grant ? req1_op  : req0_op;
    assign w_amt = w_grant ? req1_amt : req0_amt;

    // A left rotate by amt equals a right rotate by (16 - amt) mod 16. The
    // 4-bit negate gives exactly that, and maps 0 to 0.
    assign w_rot_amt = (w_op == OP_ROL) ? 4'(4'd0 - w_amt) : w_amt;

    // op[0] set means a logical (zero-fill) shift; clear means rotate.
    assign w_logical = w_op[0];

    // SLL runs through the right shifter on a bit-reversed operand and the
    // result is reversed back.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_rev
            assign w_pre_rev[gi]     = w_in[15 - gi];
            assign w_shifted_rev[gi] = w_shifted[15 - gi];
        end
    endgenerate

    assign w_pre       = (w_op == OP_SLL) ? w_pre_rev : w_in;
    assign w_stage[0]  = w_pre;

    // Log barrel shifter. Stage gi moves right by 2**gi. The bits that fall
    // off the bottom either wrap to the top (rotate) or are replaced by
    // zeros (logical shift).
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_barrel
            localparam int SH = 1 << gi;
            logic [SH-1:0] w_wrap;
            assign w_wrap = w_logical ? '0 : w_stage[gi][SH-1:0];
            assign w_stage[gi+1] = w_rot_amt[gi] ? {w_wrap, w_stage[gi][15:SH]}
                                                 : w_stage[gi];
        end
    endgenerate

    assign w_shifted = w_stage[4];
    assign w_result  = (w_op == OP_SLL) ? w_shifted_rev : w_shifted;

    // ------------------------------------------------------------------
    // Response buffer FSM
    // ------------------------------------------------------------------
    // An accept always wins over a release, so take-and-accept in one
    // cycle keeps the buffer FULL with no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_owner     <= 1'b0;
            r_rsp_valid <= 2'b00;
            r_rsp_data  <= 16'h0000;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_state     <= ST_FULL;
                        r_owner     <= w_grant;
                        r_rsp_valid <= w_grant ? 2'b10 : 2'b01;
                        r_rsp_data  <= w_result;
                    end
                end
                ST_FULL: begin
                    if (w_accept) begin
                        r_owner     <= w_grant;
                        r_rsp_valid <= w_grant ? 2'b10 : 2'b01;
                        r_rsp_data  <= w_result;
                    end else if (w_taken) begin
                        r_state     <= ST_EMPTY;
                        r_rsp_valid <= 2'b00;
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_rsp_valid <= 2'b00;
                end
            endcase
        end
    end

`ifndef SHIFT_ARB_FIXED_PRIO_EN
    // The pointer only moves on a contended grant and then favours the
    // requester that just lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= INIT_PTR;
        end else if (w_accept && w_contend) begin
            r_ptr <= !w_grant;
        end
    end
`endif

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign busy      = (r_state == ST_FULL);

endmodule

// File: tb/tb_shift_arbiter.sv
// -----------------------------------------------------------------------------
// tb_shift_arbiter
//
// Stimulus and checking are split across two processes:
//   - The stimulus process drives requests on the falling edge.
//   - A reference model predicts grants and results from the ISA definition
//     of the shift ops. Expected results are pushed into a scoreboard queue.
//   - A monitor compares the response side after each rising edge and pops
//     entries as their owner takes them.
//
// The same bench serves both the round-robin build and the
// SHIFT_ARB_FIXED_PRIO_EN build.
// -----------------------------------------------------------------------------
module tb_shift_arbiter;

`ifdef SHIFT_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif
    localparam logic INIT_PTR = 1'b0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [15:0] req0_in = '0, req1_in = '0;
    logic [1:0]  req0_op = '0, req1_op = '0;
    logic [3:0]  req0_amt = '0, req1_amt = '0;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready = 2'b00;
    logic [15:0] rsp_data;
    logic        busy;

    always #5 clk = ~clk;

    shift_arbiter #(.INIT_PTR(INIT_PTR), .RESP_HOLD(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_in    (req0_in),
        .req0_op    (req0_op),
        .req0_amt   (req0_amt),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_in    (req1_in),
        .req1_op    (req1_op),
        .req1_amt   (req1_amt),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .busy       (busy)
    );

    typedef struct {
        bit          owner;
        logic [15:0] data;
    } item_t;

    item_t sb_q[$];
    int    n_vec = 0;
    int    n_err = 0;

    // Reference model state: is a result held, who owns it, who is favoured.
    bit m_full  = 1'b0;
    bit m_owner = 1'b0;
    bit m_ptr   = INIT_PTR;

    // ISA meaning of each op, written directly as left/right shifts and
    // rotates on a 32-bit scratch value.
    function automatic logic [15:0] ref_shift(logic [15:0] x, logic [1:0] op, logic [3:0] a);
        logic [31:0] v;
        logic [31:0] r;
        int          s;
        v = {16'h0000, x};
        s = int'(a);
        case (op)
            2'b00:   r = (v << s) | (v >> (16 - s));   // ROL
            2'b01:   r = v << s;                       // SLL
            2'b10:   r = (v >> s) | (v << (16 - s));   // ROR
            default: r = v >> s;                       // SRL
        endcase
        return r[15:0];
    endfunction

    task automatic check(string name, logic [15:0] act, logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus plus the model's prediction for that cycle.
    task automatic drive(bit r, bit v0, logic [15:0] a0, logic [1:0] o0, logic [3:0] m0,
                         bit v1, logic [15:0] a1, logic [1:0] o1, logic [3:0] m1,
                         logic [1:0] rr);
        bit          taken;
        bit          can;
        bit          g;
        bit          acc;
        logic [15:0] res;
        @(negedge clk);
        rst        = r;
        req0_valid = v0; req0_in = a0; req0_op = o0; req0_amt = m0;
        req1_valid = v1; req1_in = a1; req1_op = o1; req1_amt = m1;
        rsp_ready  = rr;

        taken = m_full && rr[m_owner];
        can   = !r && (!m_full || taken);
        if (v0 && v1) g = FIXED ? 1'b0 : m_ptr;
        else          g = v1;
        acc = can && (v0 || v1);
        res = g ? ref_shift(a1, o1, m1) : ref_shift(a0, o0, m0);

        #1;
        check("req0_ready", {15'b0, req0_ready}, {15'b0, acc && !g});
        check("req1_ready", {15'b0, req1_ready}, {15'b0, acc && g});
        $display("cycle t=%0t rst=%0b v=%0b%0b rr=%b acc=%0b grant=%0d exp=%h",
                 $time, r, v1, v0, rr, acc, g, res);

        if (r) begin
            sb_q.delete();
            m_full = 1'b0;
            m_ptr  = INIT_PTR;
        end else if (acc) begin
            sb_q.push_back('{owner: g, data: res});
            m_full  = 1'b1;
            m_owner = g;
            if (v0 && v1 && !FIXED) m_ptr = !g;
        end else if (taken) begin
            m_full = 1'b0;
        end
    endtask

    task automatic idle(logic [1:0] rr);
        drive(1'b0, 1'b0, 16'h0, 2'b00, 4'h0, 1'b0, 16'h0, 2'b00, 4'h0, rr);
    endtask

    // Monitor: compares what the DUT presents after each rising edge and
    // retires the shown entry once its owner takes it.
    initial begin
        bit shown;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                check("rsp_valid", {14'b0, rsp_valid}, sb_q[0].owner ? 16'h0002 : 16'h0001);
                check("rsp_data", rsp_data, sb_q[0].data);
                check("busy", {15'b0, busy}, 16'h0001);
                shown = 1'b1;
            end else begin
                check("rsp_valid_idle", {14'b0, rsp_valid}, 16'h0000);
                check("busy_idle", {15'b0, busy}, 16'h0000);
                if (rst) check("rsp_data_rst", rsp_data, 16'h0000);
                shown = 1'b0;
            end
            @(negedge clk);
            #2;
            if (shown && sb_q.size() > 0 && rsp_ready[sb_q[0].owner]) begin
                void'(sb_q.pop_front());
            end
        end
    end

    initial begin
        // Reset
        drive(1'b1, 1'b1, 16'h1234, 2'b11, 4'h1, 1'b1, 16'h5678, 2'b10, 4'h2, 2'b11);
        drive(1'b1, 1'b0, 16'h0, 2'b00, 4'h0, 1'b0, 16'h0, 2'b00, 4'h0, 2'b11);

        // Single-requester op checks
        drive(1'b0, 1'b1, 16'h8000, 2'b11, 4'hF, 1'b0, 16'h0, 2'b00, 4'h0, 2'b11);   // SRL
        idle(2'b11);
        drive(1'b0, 1'b0, 16'h0, 2'b00, 4'h0, 1'b1, 16'h8001, 2'b00, 4'h1, 2'b11);   // ROL 1
        idle(2'b11);
        drive(1'b0, 1'b0, 16'h0, 2'b00, 4'h0, 1'b1, 16'h8001, 2'b00, 4'h0, 2'b11);   // ROL 0
        idle(2'b11);
        drive(1'b0, 1'b1, 16'h0001, 2'b01, 4'hF, 1'b0, 16'h0, 2'b00, 4'h0, 2'b11);   // SLL
        drive(1'b0, 1'b1, 16'h0001, 2'b10, 4'h4, 1'b0, 16'h0, 2'b00, 4'h0, 2'b11);   // ROR
        idle(2'b11);

        // Contention, back-to-back with both results taken every cycle
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 16'hA5C3 + 16'(i), 2'(i), 4'(i + 3),
                  1'b1, 16'h3C5A + 16'(i), 2'(i + 1), 4'(i + 7), 2'b11);
        end
        idle(2'b11);

        // Backpressure: hold a req0 result, then take-and-accept req1
        drive(1'b0, 1'b1, 16'hF00D, 2'b10, 4'h8, 1'b0, 16'h0, 2'b00, 4'h0, 2'b11);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 16'h1111, 2'b11, 4'h1, 1'b1, 16'h2222, 2'b00, 4'h2, 2'b00);
        end
        drive(1'b0, 1'b0, 16'h0, 2'b00, 4'h0, 1'b1, 16'h2222, 2'b00, 4'h2, 2'b01);
        idle(2'b11);

        // Reset while FULL with a request pending
        drive(1'b0, 1'b1, 16'hBEEF, 2'b01, 4'h3, 1'b0, 16'h0, 2'b00, 4'h0, 2'b11);
        drive(1'b0, 1'b0, 16'h0, 2'b00, 4'h0, 1'b1, 16'hCAFE, 2'b10, 4'h5, 2'b00);
        drive(1'b1, 1'b0, 16'h0, 2'b00, 4'h0, 1'b1, 16'hCAFE, 2'b10, 4'h5, 2'b00);
        drive(1'b0, 1'b0, 16'h0, 2'b00, 4'h0, 1'b1, 16'hCAFE, 2'b10, 4'h5, 2'b00);
        idle(2'b11);

        // Randomized traffic, with occasional reset
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 49) == 0),
                  1'($urandom), 16'($urandom), 2'($urandom), 4'($urandom),
                  1'($urandom), 16'($urandom), 2'($urandom), 4'($urandom),
                  2'($urandom));
        end
        idle(2'b11);
        idle(2'b11);
        idle(2'b11);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
